butterfly_r2_pipe: RTL and testbench

- Pipelined radix-2 DIT butterfly: computes X0 = A + W·B and X1 = A − W·B on complex fixed-point samples.
- Generalises the combinational add/sub butterfly with twiddle multiply, per-transaction scaling mode, symmetric saturation with overflow reporting, and valid/ready flow control.
- One sample pair per cycle.
- Sits between the FFT stage sequencer (data/twiddle fetch) and the stage write-back buffer.

---
 rtl/fft_pkg.sv | 20 ++
 rtl/sat_pkg.sv | 36 +++
 rtl/cmplx_mult_pipe.sv | 84 ++++++++
 rtl/butterfly_r2_pipe.sv | 151 +++++++++++++++
 tb/tb_butterfly_r2_pipe.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: FFT datapath types and twiddle rounding helpers.
//   cplx_wide_t    - wide signed complex value used for intermediate sums
//   tw_shift       - shift that removes the twiddle's Q1.(tw-1) scaling
//   tw_round_const - half-LSB added before that shift (round half-up)
package fft_pkg;

  typedef struct packed {
    logic signed [63:0] re;
    logic signed [63:0] im;
  } cplx_wide_t;

  function automatic int unsigned tw_shift(input int unsigned tw);
    tw_shift = tw - 1;
  endfunction

  function automatic logic signed [63:0] tw_round_const(input int unsigned tw);
    tw_round_const = 64'sd1 <<< (tw - 2);
  endfunction

endpackage

// File: rtl/sat_pkg.sv
// sat_pkg: shared fixed-point helpers.
//   sym_sat   - symmetric saturation to +/-(2^(ow-1)-1). The input is taken
//               sign-extended to 64 bits, so any input width up to 64 works.
//               'clamped' reports that the value was limited.
//   round_shr - round-half-up arithmetic shift right: (x + 2^(sh-1)) >>> sh.
//               sh must be at least 1.
package sat_pkg;

  function automatic logic signed [63:0] sym_sat(
    input  logic signed [63:0] x,
    input  int unsigned        ow,
    output logic               clamped
  );
    logic signed [63:0] lim;
    lim     = (64'sd1 <<< (ow - 1)) - 64'sd1;
    clamped = 1'b0;
    if (x > lim) begin
      sym_sat = lim;
      clamped = 1'b1;
    end else if (x < -lim) begin
      // The most-negative code is folded onto -lim as well.
      sym_sat = -lim;
      clamped = 1'b1;
    end else begin
      sym_sat = x;
    end
  endfunction

  function automatic logic signed [63:0] round_shr(
    input logic signed [63:0] x,
    input int unsigned        sh
  );
    round_shr = (x + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

endpackage

// File: rtl/cmplx_mult_pipe.sv
// cmplx_mult_pipe: two-stage complex multiply W*B for the radix-2 butterfly.
//   S1 registers the four partial products br*wr, bi*wi, br*wi, bi*wr.
//   S2 forms Re/Im, rounds away the twiddle scaling and saturates
//   symmetrically to DATAWIDTH bits; a clamp flags the transaction.
// Ports:
//   clk, rst         clock, async active-high reset
//   en               shared pipeline enable (both stages hold when 0)
//   in_valid         S1 input valid
//   b_real, b_imag   operand B (signed Q1.(DATAWIDTH-1))
//   tw_real, tw_imag twiddle W (signed Q1.(TWWIDTH-1))
//   out_valid        S2 output valid
//   wb_real, wb_imag W*B saturated to DATAWIDTH
//   wb_ovf           saturation occurred on W*B
module cmplx_mult_pipe
  import sat_pkg::*, fft_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned TWWIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] b_real,
  input  logic [DATAWIDTH-1:0] b_imag,
  input  logic [TWWIDTH-1:0]   tw_real,
  input  logic [TWWIDTH-1:0]   tw_imag,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] wb_real,
  output logic [DATAWIDTH-1:0] wb_imag,
  output logic                 wb_ovf
);

  localparam int unsigned PW = DATAWIDTH + TWWIDTH;

  logic                 v1;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

  cplx_wide_t           pre;
  logic                 c_re, c_im;
  logic [DATAWIDTH-1:0] wr_n, wi_n;

  // S1: partial products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else if (en) begin
      v1   <= in_valid;
      p_rr <= PW'($signed(b_real)) * PW'($signed(tw_real));
      p_ii <= PW'($signed(b_imag)) * PW'($signed(tw_imag));
      p_ri <= PW'($signed(b_real)) * PW'($signed(tw_imag));
      p_ir <= PW'($signed(b_imag)) * PW'($signed(tw_real));
    end
  end

  // S2: combine, round, saturate
  always_comb begin
    pre.re = 64'(p_rr) - 64'(p_ii);
    pre.im = 64'(p_ri) + 64'(p_ir);
    c_re   = 1'b0;
    c_im   = 1'b0;
    wr_n   = DATAWIDTH'(sym_sat(round_shr(pre.re, tw_shift(TWWIDTH)), DATAWIDTH, c_re));
    wi_n   = DATAWIDTH'(sym_sat(round_shr(pre.im, tw_shift(TWWIDTH)), DATAWIDTH, c_im));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      wb_real   <= '0;
      wb_imag   <= '0;
      wb_ovf    <= 1'b0;
    end else if (en) begin
      out_valid <= v1;
      wb_real   <= wr_n;
      wb_imag   <= wi_n;
      wb_ovf    <= c_re | c_im;
    end
  end

endmodule

// File: rtl/butterfly_r2_pipe.sv
// butterfly_r2_pipe: pipelined radix-2 DIT butterfly.
//   X0 = A + W*B, X1 = A - W*B on signed complex fixed-point samples.
//   Three register stages (S1/S2 in cmplx_mult_pipe, S3 here), latency 3.
//   One global enable en = ~out_valid | out_ready stalls every stage at once,
//   so no bubbles are inserted and no data are lost while backpressured.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid / in_ready      input handshake (in_ready = en)
//   a_*, b_*                 operands A, B (DATAWIDTH signed)
//   tw_*                     twiddle W (TWWIDTH signed)
//   scale_in                 1: halve results (rounded) before saturation
//   out_valid / out_ready    output handshake
//   x0_*, x1_*               results, symmetric-saturated
//   ovf_out                  some result of this transaction saturated
//   ovf_sticky / ovf_clear   accumulated overflow flag and its sync clear
module butterfly_r2_pipe
  import sat_pkg::*, fft_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned TWWIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a_real,
  input  logic [DATAWIDTH-1:0] a_imag,
  input  logic [DATAWIDTH-1:0] b_real,
  input  logic [DATAWIDTH-1:0] b_imag,
  input  logic [TWWIDTH-1:0]   tw_real,
  input  logic [TWWIDTH-1:0]   tw_imag,
  input  logic                 scale_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] x0_real,
  output logic [DATAWIDTH-1:0] x0_imag,
  output logic [DATAWIDTH-1:0] x1_real,
  output logic [DATAWIDTH-1:0] x1_imag,
  output logic                 ovf_out,
  output logic                 ovf_sticky,
  input  logic                 ovf_clear
);

  logic                 en;

  // A and scale travel alongside the multiplier stages
  logic [DATAWIDTH-1:0] a1_real, a1_imag, a2_real, a2_imag;
  logic                 sc1, sc2;

  logic                 wb_valid;
  logic [DATAWIDTH-1:0] wb_real, wb_imag;
  logic                 wb_ovf;

  cplx_wide_t           s0, s1;
  logic                 k0r, k0i, k1r, k1i;
  logic [DATAWIDTH-1:0] x0r_n, x0i_n, x1r_n, x1i_n;

  always_comb begin
    en       = ~out_valid | out_ready;
    in_ready = en;
  end

  cmplx_mult_pipe #(
    .DATAWIDTH (DATAWIDTH),
    .TWWIDTH   (TWWIDTH)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .b_real    (b_real),
    .b_imag    (b_imag),
    .tw_real   (tw_real),
    .tw_imag   (tw_imag),
    .out_valid (wb_valid),
    .wb_real   (wb_real),
    .wb_imag   (wb_imag),
    .wb_ovf    (wb_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_real <= '0;
      a1_imag <= '0;
      sc1     <= 1'b0;
      a2_real <= '0;
      a2_imag <= '0;
      sc2     <= 1'b0;
    end else if (en) begin
      a1_real <= a_real;
      a1_imag <= a_imag;
      sc1     <= scale_in;
      a2_real <= a1_real;
      a2_imag <= a1_imag;
      sc2     <= sc1;
    end
  end

  // S3: add/sub in wide precision, optional rounded halving, then clamp
  always_comb begin
    s0.re = 64'($signed(a2_real)) + 64'($signed(wb_real));
    s0.im = 64'($signed(a2_imag)) + 64'($signed(wb_imag));
    s1.re = 64'($signed(a2_real)) - 64'($signed(wb_real));
    s1.im = 64'($signed(a2_imag)) - 64'($signed(wb_imag));
    if (sc2) begin
      s0.re = round_shr(s0.re, 1);
      s0.im = round_shr(s0.im, 1);
      s1.re = round_shr(s1.re, 1);
      s1.im = round_shr(s1.im, 1);
    end
    k0r   = 1'b0;
    k0i   = 1'b0;
    k1r   = 1'b0;
    k1i   = 1'b0;
    x0r_n = DATAWIDTH'(sym_sat(s0.re, DATAWIDTH, k0r));
    x0i_n = DATAWIDTH'(sym_sat(s0.im, DATAWIDTH, k0i));
    x1r_n = DATAWIDTH'(sym_sat(s1.re, DATAWIDTH, k1r));
    x1i_n = DATAWIDTH'(sym_sat(s1.im, DATAWIDTH, k1i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      x0_real   <= '0;
      x0_imag   <= '0;
      x1_real   <= '0;
      x1_imag   <= '0;
      ovf_out   <= 1'b0;
    end else if (en) begin
      out_valid <= wb_valid;
      x0_real   <= x0r_n;
      x0_imag   <= x0i_n;
      x1_real   <= x1r_n;
      x1_imag   <= x1i_n;
      // Gated by valid so a bubble never shows a stale overflow
      ovf_out   <= wb_valid & (wb_ovf | k0r | k0i | k1r | k1i);
    end
  end

  // Clear wins over a same-cycle set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (ovf_clear) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid & out_ready & ovf_out) begin
      ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
module tb_butterfly_r2_pipe;

  localparam int unsigned DW = 16;
  localparam int unsigned TW = 16;

  logic          clk, rst;
  logic          in_valid, in_ready, scale_in, out_valid, out_ready;
  logic [DW-1:0] a_real, a_imag, b_real, b_imag;
  logic [TW-1:0] tw_real, tw_imag;
  logic [DW-1:0] x0_real, x0_imag, x1_real, x1_imag;
  logic          ovf_out, ovf_sticky, ovf_clear;

  butterfly_r2_pipe #(.DATAWIDTH(DW), .TWWIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .tw_real(tw_real), .tw_imag(tw_imag), .scale_in(scale_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0_real(x0_real), .x0_imag(x0_imag), .x1_real(x1_real), .x1_imag(x1_imag),
    .ovf_out(ovf_out), .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int id;
    int x0r, x0i, x1r, x1i;
    bit ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;
  int   or_mode = 0;
  bit   sticky_m = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) ----------
  function automatic longint fdiv(input longint n, input longint d);
    longint qt;
    qt = n / d;
    if ((n % d != 0) && (n < 0)) qt = qt - 1;
    return qt;
  endfunction

  function automatic longint clampv(input longint v, output bit c);
    longint lim;
    lim = (longint'(1) << (DW - 1)) - 1;
    c = 1'b0;
    if (v > lim)       begin c = 1'b1; return lim;  end
    else if (v < -lim) begin c = 1'b1; return -lim; end
    return v;
  endfunction

  function automatic exp_t model(input int ar, input int ai, input int br, input int bi,
                                 input int wr, input int wi, input bit sc);
    exp_t   e;
    longint wbr, wbi, s[4];
    bit     c, ov;
    ov  = 1'b0;
    wbr = fdiv(longint'(br) * wr - longint'(bi) * wi + (longint'(1) << (TW - 2)),
               longint'(1) << (TW - 1));
    wbi = fdiv(longint'(br) * wi + longint'(bi) * wr + (longint'(1) << (TW - 2)),
               longint'(1) << (TW - 1));
    wbr = clampv(wbr, c); ov |= c;
    wbi = clampv(wbi, c); ov |= c;
    s[0] = ar + wbr; s[1] = ai + wbi; s[2] = ar - wbr; s[3] = ai - wbi;
    for (int k = 0; k < 4; k++) begin
      if (sc) s[k] = fdiv(s[k] + 1, 2);
      s[k] = clampv(s[k], c);
      ov |= c;
    end
    e.id = 0;
    e.x0r = int'(s[0]); e.x0i = int'(s[1]); e.x1r = int'(s[2]); e.x1i = int'(s[3]);
    e.ovf = ov;
    return e;
  endfunction

  function automatic exp_t mk(input int x0r, input int x0i, input int x1r, input int x1i,
                              input bit ovf);
    exp_t e;
    e.id = 0; e.x0r = x0r; e.x0i = x0i; e.x1r = x1r; e.x1i = x1i; e.ovf = ovf;
    return e;
  endfunction

  function automatic int rnd_s(input int w);
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return -(1 << (w - 1));
    if (r == 1) return (1 << (w - 1)) - 1;
    return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
  endfunction

  // ---------------- driver ----------------------------------------------
  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input int wr, input int wi, input bit sc,
                      input bit use_fixed, input exp_t fixed);
    exp_t e;
    int   tmp;
    bit   done;
    @(posedge clk); #1;
    tmp = ar; a_real  = tmp[DW-1:0];
    tmp = ai; a_imag  = tmp[DW-1:0];
    tmp = br; b_real  = tmp[DW-1:0];
    tmp = bi; b_imag  = tmp[DW-1:0];
    tmp = wr; tw_real = tmp[TW-1:0];
    tmp = wi; tw_imag = tmp[TW-1:0];
    scale_in  = sc;
    in_valid  = 1'b1;
    ovf_clear = 1'b0;
    e = use_fixed ? fixed : model(ar, ai, br, bi, wr, wi, sc);
    e.id = next_id;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        next_id++;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stuck 0 for txn %0d", e.id);
    end
  endtask

  task automatic send_rand(input bit sc);
    exp_t dummy;
    dummy = mk(0, 0, 0, 0, 1'b0);
    send(rnd_s(DW), rnd_s(DW), rnd_s(DW), rnd_s(DW), rnd_s(TW), rnd_s(TW), sc, 1'b0, dummy);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    ovf_clear = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
  endtask

  task automatic drain();
    bit empty;
    idle();
    empty = 1'b0;
    for (int n = 0; n < 300 && !empty; n++) begin
      @(posedge clk);
      if (q.size() == 0) empty = 1'b1;
    end
    if (!empty) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
    end
    #1;
  endtask

  // ---------------- out_ready generator ---------------------------------
  initial begin : ready_gen
    bit pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};
    int idx = 0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        1:       begin out_ready = pat[idx % 8]; idx++; end
        2:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor / scoreboard --------------------------------
  initial begin : monitor
    bit            stall_prev = 1'b0;
    logic [DW-1:0] p0r, p0i, p1r, p1i;
    logic          povf;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        sticky_m   = 1'b0;
      end else begin
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        chk("ovf_sticky", ovf_sticky, sticky_m);
        if (stall_prev) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_x0r", x0_real, p0r);
          chk("hold_x0i", x0_imag, p0i);
          chk("hold_x1r", x1_real, p1r);
          chk("hold_x1i", x1_imag, p1i);
          chk("hold_ovf", ovf_out, povf);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: x0=(%0d,%0d) with empty queue",
                     $signed(x0_real), $signed(x0_imag));
          end else begin
            e = q.pop_front();
            chk($sformatf("x0_real#%0d", e.id), $signed(x0_real), e.x0r);
            chk($sformatf("x0_imag#%0d", e.id), $signed(x0_imag), e.x0i);
            chk($sformatf("x1_real#%0d", e.id), $signed(x1_real), e.x1r);
            chk($sformatf("x1_imag#%0d", e.id), $signed(x1_imag), e.x1i);
            chk($sformatf("ovf_out#%0d", e.id), ovf_out, e.ovf);
            if (!ovf_clear && e.ovf) sticky_m = 1'b1;
          end
        end
        if (ovf_clear) sticky_m = 1'b0;
        stall_prev = out_valid && !out_ready;
        p0r = x0_real; p0i = x0_imag; p1r = x1_real; p1i = x1_imag; povf = ovf_out;
      end
    end
  end

  // ---------------- main sequence ---------------------------------------
  initial begin : main
    rst = 1'b1; in_valid = 1'b0; scale_in = 1'b0; ovf_clear = 1'b0; out_ready = 1'b1;
    a_real = '0; a_imag = '0; b_real = '0; b_imag = '0; tw_real = '0; tw_imag = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x0_real", x0_real, 0);
    chk("rst_x1_imag", x1_imag, 0);
    chk("rst_ovf_out", ovf_out, 0);
    chk("rst_ovf_sticky", ovf_sticky, 0);
    chk("rst_in_ready", in_ready, 1);
    #11 rst = 1'b0;

    // directed cases with hand-derived results
    send(1000, 0, 500, 0, 32767, 0, 1'b0, 1'b1, mk(1500, 0, 500, 0, 1'b0));
    send(30000, 0, 10000, 0, 32767, 0, 1'b0, 1'b1, mk(32767, 0, 20000, 0, 1'b1));
    send(30000, 0, 10000, 0, 32767, 0, 1'b1, 1'b1, mk(20000, 0, 10000, 0, 1'b0));
    send(0, 0, 1000, 0, 0, -32767, 1'b0, 1'b1, mk(0, -1000, 0, 1000, 1'b0));
    send(-32768, 0, 0, 0, 32767, 0, 1'b0, 1'b1, mk(-32767, 0, -32767, 0, 1'b1));
    drain();
    chk("sticky_after_sat", ovf_sticky, 1);
    pulse_clear();
    idle();
    chk("sticky_after_clear", ovf_sticky, 0);

    // backpressure stream
    or_mode = 1;
    for (int i = 0; i < 8; i++) send_rand(1'($urandom_range(0, 1)));
    drain();
    or_mode = 0;

    // randomized traffic with bubbles, backpressure and clears
    or_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send_rand(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 29) == 0) pulse_clear();
    end
    drain();
    or_mode = 0;

    // reset with transactions in flight and the sticky flag set
    send(30000, 0, 10000, 0, 32767, 0, 1'b0, 1'b1, mk(32767, 0, 20000, 0, 1'b1));
    drain();
    idle();
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    in_valid = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_ovf_sticky", ovf_sticky, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (10) idle();
    chk("post_rst_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
